// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle MDU wait.
// Optional macro HAZARD_STAT_EN adds a free-running stall_cnt statistics output.
module hazard_ctrl #(
    parameter int         MDU_CYCLES = 4,
    parameter logic [1:0] LOAD_SRC   = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs_addr,
    input  logic       id_rs_used,
    input  logic [4:0] id_rt_addr,
    input  logic       id_rt_used,
    input  logic [4:0] exe_wr_addr,
    input  logic [1:0] exe_wdata_src,
    input  logic       branch_taken,
    input  logic       mdu_start,
    output logic       pc_hold,
    output logic       if_id_hold,
    output logic       if_id_flush,
    output logic       id_exe_pause,
    output logic       mdu_busy
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MDU_WAIT = 1'b1;

    // Wait length excludes the mdu_start cycle itself, and the cnt==0 cycle is the last one.
    localparam logic [4:0] CNT_INIT = 5'(MDU_CYCLES - 2);

    logic [0:0] state, state_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic       load_use;

    assign load_use = (exe_wdata_src == LOAD_SRC) && (exe_wr_addr != 5'd0) &&
                      ((id_rs_used && id_rs_addr == exe_wr_addr) ||
                       (id_rt_used && id_rt_addr == exe_wr_addr));

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_pause = 1'b0;
        mdu_busy     = 1'b0;
        // Outputs follow inputs combinationally, so they are masked while reset is held.
        if (rst) begin
            if (state == RUN) begin
                if (branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_exe_pause = 1'b1;
                end else begin
                    if (load_use) begin
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_exe_pause = 1'b1;
                    end
                    if (mdu_start) begin
                        state_nxt = MDU_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end else begin
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_exe_pause = 1'b1;
                mdu_busy     = 1'b1;
                if (cnt == 5'd0) state_nxt = RUN;
                else             cnt_nxt   = cnt - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         stall_cnt <= 32'd0;
        else if (pc_hold) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; outputs packed as {pc_hold, if_id_hold, if_id_flush, id_exe_pause, mdu_busy}.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs_addr, id_rt_addr, exe_wr_addr;
    logic       id_rs_used, id_rt_used;
    logic [1:0] exe_wdata_src;
    logic       branch_taken, mdu_start;
    logic       pc_hold, if_id_hold, if_id_flush, id_exe_pause, mdu_busy;
`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_CYCLES(4), .LOAD_SRC(2'b01)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs_addr   (id_rs_addr),
        .id_rs_used   (id_rs_used),
        .id_rt_addr   (id_rt_addr),
        .id_rt_used   (id_rt_used),
        .exe_wr_addr  (exe_wr_addr),
        .exe_wdata_src(exe_wdata_src),
        .branch_taken (branch_taken),
        .mdu_start    (mdu_start),
        .pc_hold      (pc_hold),
        .if_id_hold   (if_id_hold),
        .if_id_flush  (if_id_flush),
        .id_exe_pause (id_exe_pause),
        .mdu_busy     (mdu_busy)
`ifdef HAZARD_STAT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] got;
        got = {pc_hold, if_id_hold, if_id_flush, id_exe_pause, mdu_busy};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

`ifdef HAZARD_STAT_EN
    task automatic chk_stat(input string tag, input logic [31:0] exp);
        checks++;
        assert (stall_cnt === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, stall_cnt, exp);
        end
    endtask
`endif

    // Set every input, then let combinational outputs settle mid-cycle.
    task automatic drive(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                         input logic rtu, input logic [4:0] wr, input logic [1:0] src,
                         input logic br, input logic ms);
        id_rs_addr = rs; id_rs_used = rsu; id_rt_addr = rt; id_rt_used = rtu;
        exe_wr_addr = wr; exe_wdata_src = src; branch_taken = br; mdu_start = ms;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        chk("reset_idle", 5'b00000);
`ifdef HAZARD_STAT_EN
        chk_stat("reset_stat", 32'd0);
`endif
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 2'b01, 1'b1, 1'b1);
        chk("reset_masks_inputs", 5'b00000);

        @(negedge clk); rst = 1'b1; idle();
        chk("run_idle", 5'b00000);

        @(negedge clk); drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 2'b01, 1'b0, 1'b0);
        chk("load_use_rs", 5'b11010);
        @(negedge clk); idle();
        chk("load_use_one_cycle", 5'b00000);

        @(negedge clk); drive(5'd1, 1'b1, 5'd7, 1'b1, 5'd7, 2'b01, 1'b0, 1'b0);
        chk("load_use_rt", 5'b11010);

        @(negedge clk); drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 2'b01, 1'b0, 1'b0);
        chk("reg0_no_stall", 5'b00000);

        @(negedge clk); drive(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 2'b01, 1'b0, 1'b0);
        chk("rt_unused", 5'b00000);

        @(negedge clk); drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 2'b10, 1'b0, 1'b0);
        chk("non_load_src", 5'b00000);

        @(negedge clk); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b1, 1'b0);
        chk("branch_flush", 5'b00110);

        @(negedge clk); drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 2'b01, 1'b1, 1'b1);
        chk("branch_priority", 5'b00110);
        @(negedge clk); idle();
        chk("no_wait_after_branch", 5'b00000);
        @(negedge clk); idle();
        chk("still_run", 5'b00000);

        // MDU_CYCLES=4: start cycle, then exactly three busy cycles.
        @(negedge clk); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1);
        chk("mdu_start_cycle", 5'b00000);
        @(negedge clk); idle();
        chk("mdu_wait1", 5'b11011);
        @(negedge clk); drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 2'b01, 1'b1, 1'b1);
        chk("mdu_wait2_ignores", 5'b11011);
        @(negedge clk); idle();
        chk("mdu_wait3", 5'b11011);
        @(negedge clk); idle();
        chk("mdu_back_run", 5'b00000);
`ifdef HAZARD_STAT_EN
        chk_stat("stall_count", 32'd5);
`endif
        @(negedge clk); idle();
        chk("mdu_stays_run", 5'b00000);

        // Reset in the second wait cycle aborts the wait.
        @(negedge clk); drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1);
        @(negedge clk); idle();
        chk("rw_wait1", 5'b11011);
        @(negedge clk);
        chk("rw_wait2", 5'b11011);
        rst = 1'b0; #1;
        chk("rw_async_clear", 5'b00000);
`ifdef HAZARD_STAT_EN
        chk_stat("rw_stat_clear", 32'd0);
`endif
        @(negedge clk); rst = 1'b1; #1;
        chk("rw_release_run", 5'b00000);
        @(negedge clk);
        chk("rw_run_next", 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
